// File: rtl/video_sync_decoder_pkg.sv
// Shared definitions for the raster sync decoder.
// Contents: polarity defaults, coordinate width, FSM state enum, geometry record,
// 640x480 reference geometry and a saturating-increment helper.
package video_sync_decoder_pkg;

    localparam int unsigned CoordWidth = 16;
    localparam logic [CoordWidth-1:0] CountMax = 16'hFFFF;

    // Default sync polarities: 1 = a low pulse marks sync.
    localparam bit HsyncActiveLowDefault = 1'b1;
    localparam bit VsyncActiveLowDefault = 1'b1;

    typedef enum logic [1:0] {
        StWaitV,
        StMeasure,
        StVerify,
        StLocked
    } sync_state_e;

    typedef struct packed {
        logic [CoordWidth-1:0] h_total;
        logic [CoordWidth-1:0] h_active;
        logic [CoordWidth-1:0] v_total;
        logic [CoordWidth-1:0] v_active;
    } geom_t;

    localparam geom_t Geom640x480 = '{
        h_total:  16'd800,
        h_active: 16'd640,
        v_total:  16'd525,
        v_active: 16'd480
    };

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CoordWidth-1:0] sat_inc(input logic [CoordWidth-1:0] v);
        return (v == CountMax) ? v : v + 16'd1;
    endfunction

    // A saturated field means the measurement is not trustworthy.
    function automatic logic geom_saturated(input geom_t g);
        return (g.h_total == CountMax) || (g.h_active == CountMax) ||
               (g.v_total == CountMax) || (g.v_active == CountMax);
    endfunction

endpackage

// File: rtl/video_sync_decoder_sync_edge_detect.sv
// Registers one raster control input, normalises it to active-high and reports
// its level plus one-cycle leading (inactive->active) and trailing pulses.
// Ports:
//   clk    - pixel clock
//   reset  - synchronous, active-high reset
//   din    - raw input, polarity per ACTIVE_LOW
//   level  - registered active-high level
//   lead   - inactive-to-active transition pulse
//   trail  - active-to-inactive transition pulse
module video_sync_decoder_sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic lead,
    output logic trail
);

    logic cur_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= din ^ ACTIVE_LOW;
            prev_q <= cur_q;
        end
    end

    assign level = cur_q;
    assign lead  = cur_q & ~prev_q;
    assign trail = ~cur_q & prev_q;

endmodule

// File: rtl/video_sync_decoder.sv
// Receive-side raster decoder: recovers x/y of each active pixel from
// hsync/vsync/visible, measures line/frame geometry and asserts locked once
// LOCK_FRAMES consecutive frames report identical geometry.
// Ports:
//   clk, reset              - pixel clock, synchronous active-high reset
//   hsync, vsync, visible   - raster inputs (sync polarity per parameters)
//   x, y, pix_valid         - coordinates of the active pixel, 2 clocks after input
//   line_start, frame_start - pulses with x=0, and with x=0,y=0
//   h_total, h_active       - clocks per line, visible clocks per line
//   v_total, v_active       - lines per frame, visible lines per frame
//   locked                  - geometry stable; measurement outputs frozen while set
module video_sync_decoder
    import video_sync_decoder_pkg::*;
#(
    parameter bit          HSYNC_ACTIVE_LOW = HsyncActiveLowDefault,
    parameter bit          VSYNC_ACTIVE_LOW = VsyncActiveLowDefault,
    parameter int unsigned LOCK_FRAMES      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        visible,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        pix_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] h_total,
    output logic [15:0] h_active,
    output logic [15:0] v_total,
    output logic [15:0] v_active,
    output logic        locked
);

    localparam logic [4:0] LockFrames = 5'(LOCK_FRAMES);

    logic hs_level, hs_lead, hs_trail;
    logic vs_level, vs_lead, vs_trail;
    logic vis_level, vis_lead, vis_trail;

    video_sync_decoder_sync_edge_detect #(.ACTIVE_LOW(HSYNC_ACTIVE_LOW)) u_hs (
        .clk(clk), .reset(reset), .din(hsync), .level(hs_level), .lead(hs_lead), .trail(hs_trail)
    );
    video_sync_decoder_sync_edge_detect #(.ACTIVE_LOW(VSYNC_ACTIVE_LOW)) u_vs (
        .clk(clk), .reset(reset), .din(vsync), .level(vs_level), .lead(vs_lead), .trail(vs_trail)
    );
    video_sync_decoder_sync_edge_detect #(.ACTIVE_LOW(1'b0)) u_vis (
        .clk(clk), .reset(reset), .din(visible), .level(vis_level), .lead(vis_lead),
        .trail(vis_trail)
    );

    logic unused_edges;
    assign unused_edges = ^{hs_level, hs_trail, vs_level, vs_trail};

    // Coordinate and measurement state
    logic [15:0] x_q, y_q, line_cnt_q;
    logic        pix_valid_q, line_start_q, frame_start_q;
    logic [15:0] h_cnt_q, h_period_q, run_cnt_q, max_run_q, hs_lines_q, vis_lines_q;
    logic [15:0] y_new, h_period_d, max_run_d, hs_lines_d;
    geom_t       cand;

    // A visible rise coincident with vsync starts the new frame at y=0.
    assign y_new = vs_lead ? 16'd0 : line_cnt_q;

    // An hs edge coincident with vs is counted into the frame that is ending.
    assign h_period_d = hs_lead ? h_cnt_q : h_period_q;
    assign max_run_d  = (vis_trail && (run_cnt_q > max_run_q)) ? run_cnt_q : max_run_q;
    assign hs_lines_d = hs_lead ? sat_inc(hs_lines_q) : hs_lines_q;

    assign cand = '{h_total: h_period_d, h_active: max_run_d, v_total: hs_lines_d,
                    v_active: vis_lines_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            line_cnt_q    <= '0;
            pix_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            h_cnt_q       <= '0;
            h_period_q    <= '0;
            run_cnt_q     <= '0;
            max_run_q     <= '0;
            hs_lines_q    <= '0;
            vis_lines_q   <= '0;
        end else begin
            pix_valid_q   <= vis_level;
            line_start_q  <= vis_lead;
            frame_start_q <= vis_lead && (y_new == 16'd0);

            if (vis_lead) begin
                x_q <= '0;
                y_q <= y_new;
            end else if (vis_level) begin
                x_q <= sat_inc(x_q);
            end

            if (vs_lead) begin
                line_cnt_q <= vis_lead ? 16'd1 : 16'd0;
            end else if (vis_lead) begin
                line_cnt_q <= sat_inc(line_cnt_q);
            end

            // Loaded with 1 so the value seen at the next hs edge is the period.
            h_cnt_q    <= hs_lead ? 16'd1 : sat_inc(h_cnt_q);
            h_period_q <= h_period_d;

            if (vis_lead) begin
                run_cnt_q <= 16'd1;
            end else if (vis_level) begin
                run_cnt_q <= sat_inc(run_cnt_q);
            end

            if (vs_lead) begin
                max_run_q   <= '0;
                hs_lines_q  <= '0;
                vis_lines_q <= vis_lead ? 16'd1 : 16'd0;
            end else begin
                max_run_q  <= max_run_d;
                hs_lines_q <= hs_lines_d;
                if (vis_lead) begin
                    vis_lines_q <= sat_inc(vis_lines_q);
                end
            end
        end
    end

    // Lock FSM
    sync_state_e state_q, state_d;
    logic [3:0]  match_cnt_q, match_cnt_d;
    geom_t       stored_q, stored_d, geom_out_q, geom_out_d;
    logic        locked_q, locked_d;
    logic        cand_ok, cand_match;
    logic [4:0]  match_new;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StWaitV;
            match_cnt_q <= '0;
            stored_q    <= '0;
            geom_out_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            stored_q    <= stored_d;
            geom_out_q  <= geom_out_d;
            locked_q    <= locked_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        stored_d    = stored_q;
        geom_out_d  = geom_out_q;
        locked_d    = locked_q;
        cand_ok     = !geom_saturated(cand);
        cand_match  = cand_ok && (cand == stored_q);
        match_new   = ((state_q == StVerify) && cand_match) ? {1'b0, match_cnt_q} + 5'd1 : 5'd1;

        unique case (state_q)
            StWaitV: begin
                if (vs_lead) begin
                    state_d = StMeasure;
                end
            end
            StMeasure, StVerify: begin
                if (vs_lead) begin
                    stored_d    = cand;
                    match_cnt_d = match_new[3:0];
                    if (cand_ok && (match_new >= LockFrames)) begin
                        state_d    = StLocked;
                        locked_d   = 1'b1;
                        geom_out_d = cand;
                    end else begin
                        state_d = StVerify;
                    end
                end
            end
            StLocked: begin
                if (vs_lead) begin
                    if (!cand_match) begin
                        state_d     = StVerify;
                        locked_d    = 1'b0;
                        stored_d    = cand;
                        match_cnt_d = 4'd1;
                    end
                end else if (hs_lead && (h_cnt_q != stored_q.h_total)) begin
                    // Line period changed mid-frame: this frame is mixed, so it
                    // does not count as a match; the next full frame starts at 1.
                    state_d          = StVerify;
                    locked_d         = 1'b0;
                    stored_d.h_total = h_cnt_q;
                    match_cnt_d      = 4'd0;
                end
            end
            default: state_d = StWaitV;
        endcase
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_valid   = pix_valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign h_total     = geom_out_q.h_total;
    assign h_active    = geom_out_q.h_active;
    assign v_total     = geom_out_q.v_total;
    assign v_active    = geom_out_q.v_active;
    assign locked      = locked_q;

endmodule

// File: doc/video_sync_decoder.md
Name: video_sync_decoder

Overview:
Receive-side counterpart of video_timing. Consumes a raster stream's hsync/vsync/visible and recovers per-pixel x/y coordinates. Measures line and frame geometry and reports lock once the geometry has been stable for LOCK_FRAMES consecutive frames. It sits at the input of capture, overlay and self-check logic, and is loop-testable directly against video_timing outputs.

Parameters:
HSYNC_ACTIVE_LOW, 1, hsync polarity (1 = low pulse marks sync)
VSYNC_ACTIVE_LOW, 1, vsync polarity (1 = low pulse marks sync)
LOCK_FRAMES, 2, consecutive identical frame measurements required to assert locked (range 1..15)

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high reset
hsync  input  1  horizontal sync, polarity per HSYNC_ACTIVE_LOW
vsync  input  1  vertical sync, polarity per VSYNC_ACTIVE_LOW
visible  input  1  active-video qualifier
x  output  16  recovered column of current active pixel
y  output  16  recovered row of current active pixel
pix_valid  output  1  x/y describe a real active pixel
line_start  output  1  one-cycle pulse with the first active pixel of each line
frame_start  output  1  one-cycle pulse with pixel (0,0)
h_total  output  16  clocks per line (hsync leading edge to leading edge)
h_active  output  16  visible clocks per line
v_total  output  16  lines per frame (hsync leading edges between vsync leading edges)
v_active  output  16  lines containing visible pixels per frame
locked  output  1  geometry stable

Behaviour:
- Reset: x=0, y=0, pix_valid=0, line_start=0, frame_start=0, h_total=0, h_active=0, v_total=0, v_active=0, locked=0, FSM=WAIT_V. All counters and candidates are cleared. Reset mid-frame discards partial measurements.
- Stage 1: register inputs and normalise polarity to active-high hs/vs. Also keep the previous values for edge detection. A leading edge is an inactive-to-active transition.
- Stage 2: outputs are registered. Latency is 2 clocks: input visible at cycle n gives pix_valid at n+2.
- x: 0 on the first visible cycle after a visible rising edge, then +1 per visible cycle. x holds its value while visible=0.
- y: an internal line counter is cleared by a vs leading edge. On each visible rising edge, y takes that counter's value and the counter increments. The first active line after vsync is therefore y=0.
- line_start is asserted with x=0. frame_start is asserted with x=0 when y=0.
- All counters saturate at 16'hFFFF and never wrap. Any saturated measurement counts as a mismatch.
- Measurement:
  - The hsync-period counter is latched at each hs leading edge.
  - The visible run length is latched at each visible falling edge; the largest value in a frame is kept.
  - The hs-edge and visible-line counts are latched at each vs leading edge.
  - A frame's candidate = {h_total, h_active, v_total, v_active}, as latched at the vs leading edge.
- h_total/h_active/v_total/v_active outputs update only when locked rises. While locked they are stable.
- FSM:
  - WAIT_V: on a vs leading edge -> MEASURE.
  - MEASURE: on the next vs leading edge, store the candidate, match_cnt=1, -> VERIFY. If LOCK_FRAMES=1, go directly to LOCKED.
  - VERIFY: on a vs edge, if the candidate equals the stored value, increment match_cnt; when match_cnt reaches LOCK_FRAMES -> LOCKED and locked=1. If it differs, store the new candidate, match_cnt=1, stay in VERIFY.
  - LOCKED: on a vs edge with a mismatch, locked=0 the same cycle and the FSM -> VERIFY with the new candidate.
- A line whose hsync period differs from the stored h_total while LOCKED forces the same mismatch handling immediately, without waiting for vsync.
- x/y/pix_valid run regardless of lock state.
- Simultaneous vs and hs leading edges: the hs edge is counted into the ending frame, then the vs latch occurs.
- A visible rising edge coincident with a vs edge belongs to the new frame.

Decomposition:
- video_pkg (shared with video_timing): polarity constants, 16-bit coordinate width, an fsm state enum {WAIT_V, MEASURE, VERIFY, LOCKED}, and a geometry struct {h_total, h_active, v_total, v_active} for 640x480 reference values (800/640/525/480).
- One natural sub-module: sync_edge_detect. It takes one input, synchronously registers it, normalises polarity, and outputs level, lead and trail pulses. It is instantiated for hsync, vsync and visible.

Test Plan:
- Drive video_timing into this block (default 640x480 geometry). After 3 frames -> locked=1, h_total=800, h_active=640, v_total=525, v_active=480. frame_start appears exactly once per frame, 2 clocks after the first visible.
- Synthetic tiny mode: h_total=20, h_active=16, hsync width 2, v_total=10, v_active=8. The last pixel reports x=15, y=7. The line_start count per frame is 8. locked rises at the end of frame 3 with LOCK_FRAMES=2.
- Locked on the tiny mode, then switch to h_total=24: locked drops within 1 line of the first 24-clock line. It reasserts 2 frames later with h_total=24.
- Assert reset for 1 cycle mid-frame while locked: all outputs read 0 the next cycle. Relock occurs only after WAIT_V, MEASURE and VERIFY on full frames.
- Run with inverted-polarity parameters (0/0) and active-high syncs: the same measurements and coordinates as the active-low run.
- Hold visible=1 and never pulse hsync for 70000 cycles: x saturates at 16'hFFFF without wrapping and locked stays 0.
